lsu_bus_ctrl: RTL and testbench

//  Sequences one data-memory load/store at a time from the core pipeline onto the AHB-lite data port.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_store_align.sv | 12 +
 rtl/lsu_bus_ctrl.sv | 160 ++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, AHB encodings and helper functions for the load/store bus controller.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10,
      ST_ERR  = 2'b11
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = addr_lo[0];
         default: bad = (addr_lo != 2'b00);
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] lanes;
      case (size)
         SZ_B:    lanes = {4{wdata[7:0]}};
         SZ_H:    lanes = {2{wdata[15:0]}};
         default: lanes = wdata;
      endcase
      return lanes;
   endfunction

   // Size code 11 is carried as a word transfer on the bus.
   function automatic logic [2:0] ahb_size(input logic [1:0] size);
      return (size == 2'b11) ? 3'b010 : {1'b0, size};
   endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Combinational store-data lane replication onto the 32-bit AHB write bus.
module lsu_store_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [31:0] wdata,
   output logic [31:0] lane_data
);

   assign lane_data = lane_replicate(size, wdata);

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Single-outstanding load/store sequencer from the MEM stage onto the AHB-lite data port.
//  state | meaning
//  IDLE  | ready for a request; misaligned requests are rejected here
//  ADDR  | NONSEQ address phase driven, waiting for hready
//  DATA  | data phase, hwdata held, wait states counted toward timeout
//  ERR   | first error cycle seen, waiting for the second (hready=1)
module lsu_bus_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        req_in,
   output logic        req_ready_out,
   input  logic        is_store_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   input  logic [1:0]  size_in,
   input  logic        unsigned_in,
   output logic [31:0] haddr_out,
   output logic [1:0]  htrans_out,
   output logic        hwrite_out,
   output logic [2:0]  hsize_out,
   output logic [31:0] hwdata_out,
   input  logic        hready_in,
   input  logic        hresp_in,
   output logic [1:0]  lu_load_size_out,
   output logic        lu_unsigned_out,
   output logic [1:0]  lu_addr_lo_out,
   output logic        lu_ahb_resp_out,
   output logic        done_out,
   output logic        misaligned_out,
   output logic        bus_err_out,
   output logic        stall_out
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

   state_t          state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic            done_nxt, mis_nxt, berr_nxt, resp_nxt;
   logic            accept;

   logic            is_store_q, unsigned_q;
   logic [31:0]     addr_q, wdata_q;
   logic [1:0]      size_q;
   logic [2:0]      hsize_q;

   assign accept  = req_in & (state == ST_IDLE);
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         done_out        <= 1'b0;
         misaligned_out  <= 1'b0;
         bus_err_out     <= 1'b0;
         lu_ahb_resp_out <= 1'b1;
         is_store_q      <= 1'b0;
         unsigned_q      <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         size_q          <= SZ_B;
         hsize_q         <= 3'b010;
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         done_out        <= done_nxt;
         misaligned_out  <= mis_nxt;
         bus_err_out     <= berr_nxt;
         lu_ahb_resp_out <= resp_nxt;
         if (accept) begin
            is_store_q <= is_store_in;
            unsigned_q <= unsigned_in;
            addr_q     <= addr_in;
            wdata_q    <= wdata_in;
            size_q     <= size_in;
            hsize_q    <= ahb_size(size_in);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      mis_nxt   = 1'b0;
      berr_nxt  = 1'b0;
      resp_nxt  = 1'b1;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (misaligned(size_in, addr_in[1:0])) begin
                  done_nxt = 1'b1;
                  mis_nxt  = 1'b1;
               end else begin
                  state_nxt = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            if (hready_in) begin
               state_nxt = ST_DATA;
               cnt_nxt   = '0;
            end
         end
         ST_DATA: begin
            if (hresp_in) begin
               // hresp with hready high is a protocol violation; close it out as an error.
               if (hready_in) begin
                  done_nxt  = 1'b1;
                  berr_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_ERR;
               end
            end else if (hready_in) begin
               done_nxt  = 1'b1;
               resp_nxt  = is_store_q;
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt_inc;
               if (cnt_inc == CNT_MAX) begin
                  done_nxt  = 1'b1;
                  berr_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_ERR: begin
            if (hready_in) begin
               done_nxt  = 1'b1;
               berr_nxt  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   lsu_store_align u_store_align (
      .size      (size_q),
      .wdata     (wdata_q),
      .lane_data (hwdata_out)
   );

   assign req_ready_out    = (state == ST_IDLE);
   assign htrans_out       = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign haddr_out        = addr_q;
   assign hwrite_out       = is_store_q;
   assign hsize_out        = hsize_q;
   assign lu_load_size_out = size_q;
   assign lu_unsigned_out  = unsigned_q;
   assign lu_addr_lo_out   = addr_q[1:0];
   assign stall_out        = req_in & ~done_out;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed self-checking bench for lsu_bus_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_lsu_bus_ctrl;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        req_in, req_ready_out, is_store_in, unsigned_in;
   logic [31:0] addr_in, wdata_in;
   logic [1:0]  size_in;
   logic [31:0] haddr_out, hwdata_out;
   logic [1:0]  htrans_out;
   logic        hwrite_out;
   logic [2:0]  hsize_out;
   logic        hready_in, hresp_in;
   logic [1:0]  lu_load_size_out, lu_addr_lo_out;
   logic        lu_unsigned_out, lu_ahb_resp_out;
   logic        done_out, misaligned_out, bus_err_out, stall_out;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_in = ~clk_in;

   lsu_bus_ctrl #(.TIMEOUT_CYC(16)) dut (
      .clk_in           (clk_in),
      .reset_in         (reset_in),
      .req_in           (req_in),
      .req_ready_out    (req_ready_out),
      .is_store_in      (is_store_in),
      .addr_in          (addr_in),
      .wdata_in         (wdata_in),
      .size_in          (size_in),
      .unsigned_in      (unsigned_in),
      .haddr_out        (haddr_out),
      .htrans_out       (htrans_out),
      .hwrite_out       (hwrite_out),
      .hsize_out        (hsize_out),
      .hwdata_out       (hwdata_out),
      .hready_in        (hready_in),
      .hresp_in         (hresp_in),
      .lu_load_size_out (lu_load_size_out),
      .lu_unsigned_out  (lu_unsigned_out),
      .lu_addr_lo_out   (lu_addr_lo_out),
      .lu_ahb_resp_out  (lu_ahb_resp_out),
      .done_out         (done_out),
      .misaligned_out   (misaligned_out),
      .bus_err_out      (bus_err_out),
      .stall_out        (stall_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_in);
   endtask

   task automatic issue(input logic st, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns);
      req_in      = 1'b1;
      is_store_in = st;
      addr_in     = a;
      wdata_in    = wd;
      size_in     = sz;
      unsigned_in = uns;
   endtask

   task automatic reset_vals(input string tag);
      check({tag, "_htrans"}, 32'(htrans_out), 32'h0);
      check({tag, "_haddr"}, haddr_out, 32'h0);
      check({tag, "_hsize"}, 32'(hsize_out), 32'h2);
      check({tag, "_hwrite"}, 32'(hwrite_out), 32'h0);
      check({tag, "_hwdata"}, hwdata_out, 32'h0);
      check({tag, "_resp"}, 32'(lu_ahb_resp_out), 32'h1);
      check({tag, "_lusize"}, 32'(lu_load_size_out), 32'h0);
      check({tag, "_done"}, 32'(done_out), 32'h0);
      check({tag, "_ready"}, 32'(req_ready_out), 32'h1);
   endtask

   initial begin
      reset_in = 1'b1;
      req_in = 1'b0; is_store_in = 1'b0; addr_in = '0; wdata_in = '0;
      size_in = 2'b00; unsigned_in = 1'b0; hready_in = 1'b1; hresp_in = 1'b0;
      step();
      step();
      reset_vals("rst");
      reset_in = 1'b0;
      step();

      // LW 0x100, zero wait states
      issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
      check("lw_stall", 32'(stall_out), 32'h1);
      step();
      req_in = 1'b0;
      check("lw_htrans_a", 32'(htrans_out), 32'h2);
      check("lw_haddr", haddr_out, 32'h100);
      check("lw_hsize", 32'(hsize_out), 32'h2);
      check("lw_ready_a", 32'(req_ready_out), 32'h0);
      step();
      check("lw_htrans_d", 32'(htrans_out), 32'h0);
      check("lw_done_d", 32'(done_out), 32'h0);
      step();
      check("lw_done", 32'(done_out), 32'h1);
      check("lw_resp", 32'(lu_ahb_resp_out), 32'h0);
      check("lw_berr", 32'(bus_err_out), 32'h0);
      check("lw_lusize", 32'(lu_load_size_out), 32'h2);
      step();
      check("lw_done_clr", 32'(done_out), 32'h0);
      check("lw_resp_clr", 32'(lu_ahb_resp_out), 32'h1);

      // SB 0x203, two wait states
      issue(1'b1, 32'h203, 32'h0000005A, 2'b00, 1'b0);
      step();
      req_in = 1'b0;
      check("sb_htrans", 32'(htrans_out), 32'h2);
      check("sb_hsize", 32'(hsize_out), 32'h0);
      check("sb_hwrite", 32'(hwrite_out), 32'h1);
      step();
      hready_in = 1'b0;
      check("sb_hwdata0", hwdata_out, 32'h5A5A5A5A);
      step();
      check("sb_hwdata1", hwdata_out, 32'h5A5A5A5A);
      check("sb_done_w", 32'(done_out), 32'h0);
      step();
      hready_in = 1'b1;
      check("sb_hwdata2", hwdata_out, 32'h5A5A5A5A);
      check("sb_htrans_d", 32'(htrans_out), 32'h0);
      step();
      check("sb_done", 32'(done_out), 32'h1);
      check("sb_resp", 32'(lu_ahb_resp_out), 32'h1);
      check("sb_addrlo", 32'(lu_addr_lo_out), 32'h3);
      step();

      // SH 0x202, half-word replication
      issue(1'b1, 32'h202, 32'h1234ABCD, 2'b01, 1'b0);
      step();
      req_in = 1'b0;
      step();
      check("sh_hwdata", hwdata_out, 32'hABCDABCD);
      step();
      check("sh_done", 32'(done_out), 32'h1);
      step();

      // LH 0x101, misaligned
      issue(1'b0, 32'h101, 32'h0, 2'b01, 1'b1);
      check("lh_htrans0", 32'(htrans_out), 32'h0);
      step();
      req_in = 1'b0;
      check("lh_htrans1", 32'(htrans_out), 32'h0);
      check("lh_done", 32'(done_out), 32'h1);
      check("lh_mis", 32'(misaligned_out), 32'h1);
      check("lh_ready", 32'(req_ready_out), 32'h1);
      check("lh_uns", 32'(lu_unsigned_out), 32'h1);
      step();
      check("lh_htrans2", 32'(htrans_out), 32'h0);
      check("lh_mis_clr", 32'(misaligned_out), 32'h0);

      // LB 0x40, two-cycle error response
      issue(1'b0, 32'h40, 32'h0, 2'b00, 1'b0);
      step();
      req_in = 1'b0;
      step();
      hready_in = 1'b0; hresp_in = 1'b1;
      step();
      hready_in = 1'b1;
      check("lb_err_htrans", 32'(htrans_out), 32'h0);
      check("lb_err_ready", 32'(req_ready_out), 32'h0);
      check("lb_err_done", 32'(done_out), 32'h0);
      step();
      hresp_in = 1'b0;
      check("lb_done", 32'(done_out), 32'h1);
      check("lb_berr", 32'(bus_err_out), 32'h1);
      check("lb_mis", 32'(misaligned_out), 32'h0);
      check("lb_resp", 32'(lu_ahb_resp_out), 32'h1);
      step();

      // LW 0x80, wait-state timeout after 16 cycles
      issue(1'b0, 32'h80, 32'h0, 2'b10, 1'b0);
      step();
      req_in = 1'b0;
      step();
      hready_in = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         check($sformatf("to_wait%0d", i), 32'(done_out), 32'h0);
      end
      step();
      check("to_ready16", 32'(req_ready_out), 32'h1);
      check("to_done", 32'(done_out), 32'h1);
      check("to_berr", 32'(bus_err_out), 32'h1);
      check("to_resp", 32'(lu_ahb_resp_out), 32'h1);
      hready_in = 1'b1;
      step();

      // Reset in DATA, then a clean load
      issue(1'b0, 32'h104, 32'h0, 2'b10, 1'b1);
      step();
      req_in = 1'b0;
      step();
      hready_in = 1'b0;
      #2 reset_in = 1'b1;
      #1 reset_vals("mid");
      step();
      reset_in = 1'b0;
      hready_in = 1'b1;
      step();
      check("post_done", 32'(done_out), 32'h0);
      issue(1'b0, 32'h102, 32'h0, 2'b01, 1'b0);
      step();
      req_in = 1'b0;
      check("post_htrans", 32'(htrans_out), 32'h2);
      check("post_hsize", 32'(hsize_out), 32'h1);
      step();
      step();
      check("post_done2", 32'(done_out), 32'h1);
      check("post_resp", 32'(lu_ahb_resp_out), 32'h0);
      check("post_addrlo", 32'(lu_addr_lo_out), 32'h2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
